// File: rtl/in_unit_if.sv
// in_unit_if: handshake bundle between the IN unit and its environment.
// Ports (signals): receiver byte input with ready, IN issue handshake with
// ROB tag, ROB head tag, flush, result-bus request/grant, result broadcast
// (valid/tag/data) and the sticky overrun flag.
interface in_unit_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 receiver_valid;
    logic [7:0]           receiver_data;
    logic                 receiver_ready;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [ROB_WIDTH-1:0] issue_tag;
    logic [ROB_WIDTH-1:0] rob_head_tag;
    logic                 flush;
    logic                 cdb_req;
    logic                 cdb_grant;
    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] cdb_tag;
    logic [31:0]          cdb_data;
    logic                 overrun;

    modport master (
        output receiver_valid, receiver_data, issue_valid, issue_tag,
               rob_head_tag, flush, cdb_grant,
        input  receiver_ready, issue_ready, cdb_req, cdb_valid, cdb_tag,
               cdb_data, overrun
    );

    modport slave (
        input  receiver_valid, receiver_data, issue_valid, issue_tag,
               rob_head_tag, flush, cdb_grant,
        output receiver_ready, issue_ready, cdb_req, cdb_valid, cdb_tag,
               cdb_data, overrun
    );
endinterface

// File: rtl/in_unit.sv
// in_unit: buffers received bytes and hands one to each IN instruction once it reaches the ROB head.
// Ports: clk_i clock, reset_i synchronous active-low reset, bus (slave side of
// in_unit_if) carrying receiver, issue, flush, result-bus and overrun signals.
module in_unit #(
    parameter int N_ENTRY    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int ROB_WIDTH  = 4
) (
    input logic        clk_i,
    input logic        reset_i,
    in_unit_if.slave   bus
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = N_ENTRY > 1 ? $clog2(N_ENTRY) : 1;
    localparam int QW = $clog2(N_ENTRY + 1);

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0] tag_q [N_ENTRY];
    logic [FW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [QW-1:0]        pcnt_q, pcnt_d;
    logic                 overrun_q, overrun_d;
    logic                 valid_q;
    logic [ROB_WIDTH-1:0] out_tag_q;
    logic [7:0]           out_byte_q;
    logic                 push, fire, issue;

    // Pending queue depth need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(N_ENTRY - 1) ? '0 : p + 1'b1;
    endfunction

    assign bus.receiver_ready = cnt_q < CW'(FIFO_DEPTH);
    // Only the IN at the ROB head may consume a byte: reading the receiver is not undoable.
    assign bus.cdb_req        = pcnt_q != '0 && cnt_q != '0 && tag_q[head_q] == bus.rob_head_tag;
    assign fire               = bus.cdb_req && bus.cdb_grant;
    assign bus.issue_ready    = pcnt_q < QW'(N_ENTRY) || fire;
    assign push               = bus.receiver_valid && bus.receiver_ready;
    assign issue              = bus.issue_valid && bus.issue_ready && !bus.flush;
    assign bus.cdb_valid      = valid_q;
    assign bus.cdb_tag        = out_tag_q;
    assign bus.cdb_data       = {24'b0, out_byte_q};
    assign bus.overrun        = overrun_q;

    always_comb begin
        wr_d      = push ? wr_q + 1'b1 : wr_q;
        rd_d      = fire ? rd_q + 1'b1 : rd_q;
        cnt_d     = cnt_q + CW'(push) - CW'(fire);
        overrun_d = overrun_q || (bus.receiver_valid && !bus.receiver_ready);
        // A fire in the flush cycle still completes; the queue simply ends empty.
        head_d    = bus.flush ? '0 : fire ? nxt(head_q) : head_q;
        tail_d    = bus.flush ? '0 : issue ? nxt(tail_q) : tail_q;
        pcnt_d    = bus.flush ? '0 : pcnt_q + QW'(issue) - QW'(fire);
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= bus.receiver_data;
        if (issue) tag_q[tail_q] <= bus.issue_tag;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            pcnt_q     <= '0;
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
            out_tag_q  <= '0;
            out_byte_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            pcnt_q    <= pcnt_d;
            overrun_q <= overrun_d;
            valid_q   <= fire;
            if (fire) begin
                out_tag_q  <= tag_q[head_q];
                out_byte_q <= mem_q[rd_q];
            end
        end
    end
endmodule

// File: tb/tb_in_unit.sv
// tb_in_unit: directed stimulus with a scoreboard queue checked by an independent result-bus monitor.
module tb_in_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q [$];

    in_unit_if #(.ROB_WIDTH(4)) bus ();

    in_unit #(.N_ENTRY(4), .FIFO_DEPTH(16), .ROB_WIDTH(4)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [35:0] a, input logic [35:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.receiver_valid = 1'b1;
        bus.receiver_data  = b;
        step();
        bus.receiver_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] t);
        bus.issue_valid = 1'b1;
        bus.issue_tag   = t;
        step();
        bus.issue_valid = 1'b0;
    endtask

    task automatic deliver(input logic [3:0] t, input logic [7:0] b);
        bus.rob_head_tag = t;
        bus.cdb_grant    = 1'b1;
        #1;
        chk("cdb_req_at_head", 36'(bus.cdb_req), 36'd1);
        exp_q.push_back({t, 24'b0, b});
        step();
        bus.cdb_grant = 1'b0;
    endtask

    // Monitor: every broadcast must match the oldest expected result.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus.cdb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cdb: got tag %0h data %0h expected no broadcast", bus.cdb_tag, bus.cdb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.cdb_tag, bus.cdb_data} !== e) begin
                        errors++;
                        $display("FAIL cdb_result: got %0h expected %0h", {bus.cdb_tag, bus.cdb_data}, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.receiver_valid = 1'b0;
        bus.receiver_data  = '0;
        bus.issue_valid    = 1'b0;
        bus.issue_tag      = '0;
        bus.rob_head_tag   = '0;
        bus.flush          = 1'b0;
        bus.cdb_grant      = 1'b0;
        step();
        step();
        chk("rst_receiver_ready", 36'(bus.receiver_ready), 36'd1);
        chk("rst_issue_ready", 36'(bus.issue_ready), 36'd1);
        chk("rst_cdb_req", 36'(bus.cdb_req), 36'd0);
        chk("rst_cdb_valid", 36'(bus.cdb_valid), 36'd0);
        chk("rst_cdb_tag_data", {bus.cdb_tag, bus.cdb_data}, 36'd0);
        chk("rst_overrun", 36'(bus.overrun), 36'd0);
        reset = 1'b1;
        step();

        // Single byte to single IN; entry not visible in its issue cycle.
        send_byte(8'h41);
        bus.issue_valid  = 1'b1;
        bus.issue_tag    = 4'd3;
        bus.rob_head_tag = 4'd3;
        bus.cdb_grant    = 1'b1;
        #1;
        chk("req_in_issue_cycle", 36'(bus.cdb_req), 36'd0);
        step();
        bus.issue_valid = 1'b0;
        #1;
        chk("req_after_issue", 36'(bus.cdb_req), 36'd1);
        exp_q.push_back({4'd3, 32'h41});
        step();
        bus.cdb_grant = 1'b0;
        step();

        // Non-speculative ordering: tag 6 at ROB head cannot bypass tag 5.
        send_byte(8'h10);
        send_byte(8'h20);
        bus.rob_head_tag = 4'd6;
        issue(4'd5);
        issue(4'd6);
        bus.cdb_grant = 1'b1;
        #1;
        chk("req_not_head", 36'(bus.cdb_req), 36'd0);
        step();
        bus.cdb_grant = 1'b0;
        deliver(4'd5, 8'h10);
        deliver(4'd6, 8'h20);
        step();

        // Full pending queue; held issue accepted in the fire cycle, enters at tail.
        bus.rob_head_tag = 4'd0;
        issue(4'd1);
        issue(4'd2);
        issue(4'd3);
        issue(4'd4);
        #1;
        chk("issue_ready_full", 36'(bus.issue_ready), 36'd0);
        bus.issue_valid = 1'b1;
        bus.issue_tag   = 4'd7;
        step();
        chk("issue_ready_held", 36'(bus.issue_ready), 36'd0);
        send_byte(8'h55);
        bus.rob_head_tag = 4'd1;
        bus.cdb_grant    = 1'b1;
        #1;
        chk("issue_ready_on_fire", 36'(bus.issue_ready), 36'd1);
        exp_q.push_back({4'd1, 32'h55});
        step();
        bus.issue_valid = 1'b0;
        bus.cdb_grant   = 1'b0;
        send_byte(8'h56);
        send_byte(8'h57);
        send_byte(8'h58);
        send_byte(8'h59);
        deliver(4'd2, 8'h56);
        deliver(4'd3, 8'h57);
        deliver(4'd4, 8'h58);
        deliver(4'd7, 8'h59);
        step();

        // Flush in a fire cycle: broadcast completes, issue dropped, bytes kept.
        bus.rob_head_tag = 4'd0;
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        issue(4'd8);
        issue(4'd9);
        bus.rob_head_tag = 4'd8;
        bus.cdb_grant    = 1'b1;
        bus.flush        = 1'b1;
        bus.issue_valid  = 1'b1;
        bus.issue_tag    = 4'd12;
        #1;
        chk("req_flush_cycle", 36'(bus.cdb_req), 36'd1);
        exp_q.push_back({4'd8, 32'h61});
        step();
        bus.flush        = 1'b0;
        bus.cdb_grant    = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.rob_head_tag = 4'd12;
        #1;
        chk("req_after_flush", 36'(bus.cdb_req), 36'd0);
        chk("issue_ready_after_flush", 36'(bus.issue_ready), 36'd1);
        issue(4'd10);
        deliver(4'd10, 8'h62);
        issue(4'd11);
        deliver(4'd11, 8'h63);
        step();

        // Byte FIFO overflow, overrun, and push dropped during pop while full.
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        #1;
        chk("receiver_ready_full", 36'(bus.receiver_ready), 36'd0);
        chk("overrun_before_drop", 36'(bus.overrun), 36'd0);
        send_byte(8'h11);
        chk("overrun_set", 36'(bus.overrun), 36'd1);
        issue(4'd0);
        bus.receiver_valid = 1'b1;
        bus.receiver_data  = 8'hEE;
        deliver(4'd0, 8'h01);
        bus.receiver_valid = 1'b0;
        #1;
        chk("receiver_ready_after_pop", 36'(bus.receiver_ready), 36'd1);
        for (int i = 1; i < 16; i++) begin
            issue(4'(i));
            deliver(4'(i), 8'(i + 1));
        end
        issue(4'd5);
        bus.rob_head_tag = 4'd5;
        #1;
        chk("req_fifo_empty", 36'(bus.cdb_req), 36'd0);
        chk("overrun_sticky", 36'(bus.overrun), 36'd1);
        step();

        // Mid-operation reset with a would-be fire in the reset cycle.
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        issue(4'd13);
        issue(4'd14);
        bus.cdb_grant = 1'b1;
        reset         = 1'b0;
        step();
        reset         = 1'b1;
        bus.cdb_grant = 1'b0;
        #1;
        chk("mid_rst_receiver_ready", 36'(bus.receiver_ready), 36'd1);
        chk("mid_rst_issue_ready", 36'(bus.issue_ready), 36'd1);
        chk("mid_rst_overrun", 36'(bus.overrun), 36'd0);
        chk("mid_rst_cdb_req", 36'(bus.cdb_req), 36'd0);
        chk("mid_rst_cdb_valid", 36'(bus.cdb_valid), 36'd0);
        step();
        step();
        issue(4'd5);
        #1;
        chk("req_no_byte_after_rst", 36'(bus.cdb_req), 36'd0);
        send_byte(8'h77);
        deliver(4'd5, 8'h77);
        repeat (4) step();
        chk("scoreboard_drained", 36'(exp_q.size()), 36'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
